mem_bus_scheduler: RTL

//  Shares the single lowX memory bus between NUM_REQ cache-side requesters (0=icache, 1=dcache,
//  2=uncached/peripheral path) with round-robin fairness, one outstanding transaction at a time.
//  It sits between the cache miss ports and the external memory bus.
//  It also bounds every transaction with a watchdog, so a hung memory returns an error instead of a deadlock.

---
 rtl/mem_bus_scheduler.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_scheduler.sv
// mem_bus_scheduler
//   Shares one memory bus between NUM_REQ cache-side requesters
//   (0 = icache, 1 = dcache, 2 = uncached/peripheral) with round-robin
//   fairness and a single outstanding transaction. Every transaction is
//   bounded by a watchdog, so a hung memory yields an error response
//   instead of a deadlock.
//
// Ports
//   clk_i, rst_ni       clock (rising edge), asynchronous active-low reset
//   req_valid_i/ready_o per-requester handshake; ready is one-hot or zero
//   req_addr_i/we_i/wdata_i  packed per-requester request fields
//   res_valid_o         one-cycle response pulse to the owning requester
//   res_data_o/err_o    shared response data / timeout flag
//   mem_req_*           request channel towards memory (valid/ready)
//   mem_res_valid_i/data_i  response channel from memory
//   busy_o              scheduler is not idle
//   stray_rsp_o         pulse: memory responded when no response was expected
module mem_bus_scheduler #(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 128,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0]        req_we_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        res_valid_o,
    output logic [DATA_W-1:0]         res_data_o,
    output logic                      res_err_o,
    output logic                      mem_req_valid_o,
    input  logic                      mem_req_ready_i,
    output logic [ADDR_W-1:0]         mem_req_addr_o,
    output logic                      mem_req_we_o,
    output logic [DATA_W-1:0]         mem_req_wdata_o,
    input  logic                      mem_res_valid_i,
    input  logic [DATA_W-1:0]         mem_res_data_i,
    output logic                      busy_o,
    output logic                      stray_rsp_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   last_grant, owner, winner;
    int                 lg_int;
    logic               found;
    logic [ADDR_W-1:0]  win_addr, addr_q;
    logic               win_we, we_q;
    logic [DATA_W-1:0]  win_wdata, wdata_q, rdata_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt;
    logic               stray_q;
    logic               handshake, complete, timeout;

    assign lg_int = int'(last_grant);

    // Round-robin pick: the lowest valid index above last_grant wins; if
    // there is none, the search wraps to the lowest valid index overall.
    // The second loop overrides the first, giving that priority order.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i] && (i <= lg_int)) begin
                found  = 1'b1;
                winner = IDX_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i] && (i > lg_int)) begin
                found  = 1'b1;
                winner = IDX_W'(i);
            end
        end
    end

    always_comb begin
        win_addr  = '0;
        win_we    = 1'b0;
        win_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IDX_W'(i)) begin
                win_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
                win_we    = req_we_i[i];
                win_wdata = req_wdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign handshake = (state == ISSUE) && mem_req_ready_i;
    assign complete  = (state == WAIT) && mem_res_valid_i;
    assign timeout   = ((state == ISSUE) || (state == WAIT)) &&
                       (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A timeout takes priority over an ISSUE handshake (the request is
    // dropped), but a real completion in WAIT beats a same-cycle timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = ISSUE;
            ISSUE: begin
                if (timeout)        state_nxt = RESP;
                else if (handshake) state_nxt = WAIT;
            end
            WAIT:    if (complete || timeout) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ready is also masked by rst_ni so nothing is offered while reset is held.
    always_comb begin
        req_ready_o = '0;
        res_valid_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_o[i] = rst_ni && (state == IDLE) && found && (winner == IDX_W'(i));
            res_valid_o[i] = (state == RESP) && (owner == IDX_W'(i));
        end
    end

    assign mem_req_valid_o = (state == ISSUE);
    assign mem_req_addr_o  = (state == ISSUE) ? addr_q  : '0;
    assign mem_req_we_o    = (state == ISSUE) && we_q;
    assign mem_req_wdata_o = (state == ISSUE) ? wdata_q : '0;
    assign res_data_o      = (state == RESP)  ? rdata_q : '0;
    assign res_err_o       = (state == RESP)  && err_q;
    assign busy_o          = (state != IDLE);
    assign stray_rsp_o     = stray_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant <= IDX_W'(NUM_REQ - 1);
            owner      <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt        <= '0;
            stray_q    <= 1'b0;
        end else begin
            if ((state == IDLE) && found) begin
                owner   <= winner;
                addr_q  <= win_addr;
                we_q    <= win_we;
                wdata_q <= win_wdata;
                cnt     <= '0;
            end else if ((state == ISSUE) || (state == WAIT)) begin
                cnt <= cnt + 1'b1;
            end
            if (complete) begin
                rdata_q <= mem_res_data_i;
                err_q   <= 1'b0;
            end else if (timeout) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
            if (state == RESP) begin
                last_grant <= owner;
            end
            // Any response outside WAIT (including the ISSUE handshake cycle
            // and late responses after a timeout or reset) is dropped.
            stray_q <= mem_res_valid_i && (state != WAIT);
        end
    end

endmodule
